// File: rtl/uart_rx_cfg.sv
// Parametrised oversampling UART receiver.
// Recovers frames of DATA_BITS data bits (LSB first), optional odd/even parity
// and one or two stop bits. Each frame is presented on a valid/ready port with
// per-frame error flags.
module uart_rx_cfg #(
   parameter int unsigned CLKS_PER_BIT = 868,
   parameter int unsigned DATA_BITS    = 8,
   parameter int unsigned PARITY       = 0,
   parameter int unsigned STOP_BITS    = 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 rx_in,
   output logic [DATA_BITS-1:0] data_out,
   output logic                 data_valid,
   input  logic                 data_ready,
   output logic                 rx_busy,
   output logic                 frame_err,
   output logic                 parity_err,
   output logic                 overrun_err
);

   localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
   localparam int unsigned IDX_W = $clog2(DATA_BITS + 1);

   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_BITS - 1);
   localparam logic             STOP_LAST = 1'(STOP_BITS - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_DONE,
      S_BREAK
   } state_t;

   state_t               state;
   logic [CNT_W-1:0]     cnt;
   logic [IDX_W-1:0]     bit_idx;
   logic                 stop_idx;
   logic [DATA_BITS-1:0] shreg;
   logic                 ferr_acc;
   logic                 perr_acc;
   logic                 rx_meta;
   logic                 rx_s;

   // Two-flop synchroniser; the line idles high so both flops reset to 1.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= rx_in;
         rx_s    <= rx_meta;
      end
   end

   // Frame recovery FSM with output handshake; all outputs are registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state       <= S_IDLE;
         cnt         <= '0;
         bit_idx     <= '0;
         stop_idx    <= 1'b0;
         shreg       <= '0;
         ferr_acc    <= 1'b0;
         perr_acc    <= 1'b0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_err   <= 1'b0;
         parity_err  <= 1'b0;
         overrun_err <= 1'b0;
         rx_busy     <= 1'b0;
      end else begin
         overrun_err <= 1'b0;
         if (data_valid && data_ready) begin
            data_valid <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (!rx_s) begin
                  state   <= S_START;
                  cnt     <= '0;
                  rx_busy <= 1'b1;
               end
            end

            // Re-check the line half a bit after the falling edge to reject glitches.
            S_START: begin
               if (cnt == HALF_LAST) begin
                  cnt <= '0;
                  if (rx_s) begin
                     state   <= S_IDLE;
                     rx_busy <= 1'b0;
                  end else begin
                     state    <= S_DATA;
                     bit_idx  <= '0;
                     stop_idx <= 1'b0;
                     ferr_acc <= 1'b0;
                     perr_acc <= 1'b0;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Mid-bit samples shift in from the top so the first bit ends at LSB.
            S_DATA: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  shreg <= {rx_s, shreg[DATA_BITS-1:1]};
                  if (bit_idx == DATA_LAST) begin
                     state <= (PARITY != 0) ? S_PARITY : S_STOP;
                  end else begin
                     bit_idx <= bit_idx + IDX_W'(1);
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Odd parity expects an odd count of ones across data plus parity bit.
            S_PARITY: begin
               if (cnt == BIT_LAST) begin
                  cnt   <= '0;
                  state <= S_STOP;
                  if (PARITY == 1) begin
                     perr_acc <= ~(^shreg ^ rx_s);
                  end else begin
                     perr_acc <= ^shreg ^ rx_s;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Any low stop sample marks the frame as a framing error.
            S_STOP: begin
               if (cnt == BIT_LAST) begin
                  cnt <= '0;
                  if (!rx_s) begin
                     ferr_acc <= 1'b1;
                  end
                  if (stop_idx == STOP_LAST) begin
                     state <= S_DONE;
                  end else begin
                     stop_idx <= 1'b1;
                  end
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end

            // Hand the frame over, or drop it if the previous word is still held.
            S_DONE: begin
               if (!data_valid || data_ready) begin
                  data_out   <= shreg;
                  frame_err  <= ferr_acc;
                  parity_err <= perr_acc;
                  data_valid <= 1'b1;
               end else begin
                  overrun_err <= 1'b1;
               end
               rx_busy <= 1'b0;
               state   <= rx_s ? S_IDLE : S_BREAK;
            end

            // A held-low line yields one frame only; wait for it to return high.
            S_BREAK: begin
               if (rx_s) begin
                  state <= S_IDLE;
               end
            end

            default: begin
               state   <= S_IDLE;
               rx_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: four instances cover 8N1, 8E1, 9N2 and 5O1.
`timescale 1ns/1ps
module tb_uart_rx_cfg;

   localparam int CPB = 16;
   localparam int NI  = 4;

   logic clk = 1'b0;
   logic rst;
   logic rx    [NI];
   logic ready [NI];
   logic valid [NI];
   logic busy  [NI];
   logic ferr  [NI];
   logic perr  [NI];
   logic ovr   [NI];
   logic [8:0] dout [NI];

   logic [7:0] dout_a;
   logic [7:0] dout_b;
   logic [8:0] dout_c;
   logic [4:0] dout_d;

   typedef struct {
      int         id;
      logic [8:0] data;
      logic       fe;
      logic       pe;
   } exp_t;

   exp_t exp_q[$];
   exp_t mon_e;
   int   n_cmp = 0;
   int   n_bad = 0;
   int   ovr_seen [NI];
   int   exp_ovr  [NI];
   int   busy_cnt [NI];

   always #5 clk = ~clk;

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
      .clk(clk), .rst(rst), .rx_in(rx[0]), .data_out(dout_a), .data_valid(valid[0]),
      .data_ready(ready[0]), .rx_busy(busy[0]), .frame_err(ferr[0]),
      .parity_err(perr[0]), .overrun_err(ovr[0]));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
      .clk(clk), .rst(rst), .rx_in(rx[1]), .data_out(dout_b), .data_valid(valid[1]),
      .data_ready(ready[1]), .rx_busy(busy[1]), .frame_err(ferr[1]),
      .parity_err(perr[1]), .overrun_err(ovr[1]));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(9), .PARITY(0), .STOP_BITS(2)) u_c (
      .clk(clk), .rst(rst), .rx_in(rx[2]), .data_out(dout_c), .data_valid(valid[2]),
      .data_ready(ready[2]), .rx_busy(busy[2]), .frame_err(ferr[2]),
      .parity_err(perr[2]), .overrun_err(ovr[2]));

   uart_rx_cfg #(.CLKS_PER_BIT(CPB), .DATA_BITS(5), .PARITY(1), .STOP_BITS(1)) u_d (
      .clk(clk), .rst(rst), .rx_in(rx[3]), .data_out(dout_d), .data_valid(valid[3]),
      .data_ready(ready[3]), .rx_busy(busy[3]), .frame_err(ferr[3]),
      .parity_err(perr[3]), .overrun_err(ovr[3]));

   assign dout[0] = 9'(dout_a);
   assign dout[1] = 9'(dout_b);
   assign dout[2] = dout_c;
   assign dout[3] = 9'(dout_d);

   function automatic int nbits_of(input int i);
      case (i)
         2:       return 9;
         3:       return 5;
         default: return 8;
      endcase
   endfunction

   // 0 = none, 1 = odd, 2 = even
   function automatic int pmode_of(input int i);
      case (i)
         1:       return 2;
         3:       return 1;
         default: return 0;
      endcase
   endfunction

   function automatic int nstop_of(input int i);
      return (i == 2) ? 2 : 1;
   endfunction

   function automatic logic [8:0] mask_of(input int i);
      logic [8:0] one;
      one = 9'h1;
      return (one << nbits_of(i)) - one;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_bad++;
         $display("FAIL %s: got %0h required %0h", name, act, req);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // Reference model: what the receiver must report for a frame sent on line id.
   task automatic expect_frame(input int id, input logic [8:0] d, input logic pflip,
                               input logic [1:0] stops);
      exp_t e;
      e.id   = id;
      e.data = d & mask_of(id);
      e.pe   = (pmode_of(id) != 0) && pflip;
      e.fe   = 1'b0;
      for (int k = 0; k < nstop_of(id); k++) begin
         if (!stops[k]) e.fe = 1'b1;
      end
      exp_q.push_back(e);
   endtask

   // Drive one frame onto line id; pflip inverts the correct parity bit.
   task automatic send(input int id, input logic [8:0] d, input logic pflip,
                       input logic [1:0] stops);
      logic par;
      rx[id] = 1'b0;
      tick(CPB);
      for (int k = 0; k < nbits_of(id); k++) begin
         rx[id] = d[k];
         tick(CPB);
      end
      if (pmode_of(id) != 0) begin
         par = 1'b0;
         for (int k = 0; k < nbits_of(id); k++) par = par ^ d[k];
         if (pmode_of(id) == 1) par = ~par;
         rx[id] = par ^ pflip;
         tick(CPB);
      end
      for (int k = 0; k < nstop_of(id); k++) begin
         rx[id] = stops[k];
         tick(CPB);
      end
      rx[id] = 1'b1;
      tick(2 * CPB);
   endtask

   task automatic wait_drain(input string name);
      int k;
      k = 0;
      while (exp_q.size() != 0 && k < 400) begin
         tick(1);
         k++;
      end
      chk(name, exp_q.size(), 0);
      if (exp_q.size() != 0) exp_q.delete();
   endtask

   // Monitor: every accepted word is matched against the head of the scoreboard.
   always @(negedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NI; i++) begin
            if (ovr[i]) ovr_seen[i]++;
            if (busy[i]) busy_cnt[i]++;
            if (valid[i] && ready[i]) begin
               n_cmp++;
               if (exp_q.size() == 0) begin
                  n_bad++;
                  $display("FAIL frame_unexpected: inst %0d got data=%0h fe=%b pe=%b, required no frame",
                           i, dout[i], ferr[i], perr[i]);
               end else begin
                  mon_e = exp_q.pop_front();
                  if (mon_e.id != i || mon_e.data !== dout[i] || mon_e.fe !== ferr[i] ||
                      mon_e.pe !== perr[i]) begin
                     n_bad++;
                     $display("FAIL frame_compare: got inst %0d data=%0h fe=%b pe=%b required inst %0d data=%0h fe=%b pe=%b",
                              i, dout[i], ferr[i], perr[i], mon_e.id, mon_e.data, mon_e.fe, mon_e.pe);
                  end
               end
            end
         end
      end
   end

   // Absolute time bound so the run always terminates.
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [8:0] d;
      logic       flip;
      logic [1:0] stops;
      logic       rdy;

      rst = 1'b1;
      for (int i = 0; i < NI; i++) begin
         rx[i]       = 1'b1;
         ready[i]    = 1'b0;
         ovr_seen[i] = 0;
         exp_ovr[i]  = 0;
         busy_cnt[i] = 0;
      end
      tick(3);
      for (int i = 0; i < NI; i++) begin
         chk($sformatf("reset_outputs_inst%0d", i),
             32'({valid[i], busy[i], ovr[i], ferr[i], perr[i], dout[i]}), 0);
      end
      rst = 1'b0;
      tick(4);

      // 8N1 0xA5 held until ready, then cleared the following cycle
      expect_frame(0, 9'h0A5, 1'b0, 2'b11);
      send(0, 9'h0A5, 1'b0, 2'b11);
      chk("a5_valid", 32'(valid[0]), 1);
      tick(30);
      chk("a5_hold", 32'(valid[0]), 1);
      ready[0] = 1'b1;
      tick(1);
      ready[0] = 1'b0;
      chk("a5_clear", 32'(valid[0]), 0);
      chk("a5_consumed", exp_q.size(), 0);

      // even parity: 0x07 has three ones, so bit 1 is correct and bit 0 is an error
      ready[1] = 1'b1;
      expect_frame(1, 9'h007, 1'b0, 2'b11);
      send(1, 9'h007, 1'b0, 2'b11);
      expect_frame(1, 9'h007, 1'b1, 2'b11);
      send(1, 9'h007, 1'b1, 2'b11);
      wait_drain("parity_drain");
      ready[1] = 1'b0;

      // break: zero data, low stop bit, line held low for 40 more bit times
      ready[0] = 1'b1;
      expect_frame(0, 9'h000, 1'b0, 2'b00);
      rx[0] = 1'b0;
      tick(11 * CPB);
      busy_cnt[0] = 0;
      tick(39 * CPB);
      chk("break_busy_cycles", busy_cnt[0], 0);
      chk("break_one_frame", exp_q.size(), 0);
      rx[0] = 1'b1;
      tick(2 * CPB);
      expect_frame(0, 9'h03C, 1'b0, 2'b11);
      send(0, 9'h03C, 1'b0, 2'b11);
      wait_drain("break_recover_drain");
      ready[0] = 1'b0;

      // overrun: second frame dropped while first still held
      exp_ovr[0] = exp_ovr[0] + 1;
      expect_frame(0, 9'h011, 1'b0, 2'b11);
      send(0, 9'h011, 1'b0, 2'b11);
      send(0, 9'h022, 1'b0, 2'b11);
      chk("ovr_pulses", ovr_seen[0], 1);
      chk("ovr_valid", 32'(valid[0]), 1);
      chk("ovr_keep_data", 32'(dout[0]), 32'h11);
      ready[0] = 1'b1;
      tick(1);
      ready[0] = 1'b0;
      chk("ovr_consumed_valid", 32'(valid[0]), 0);
      chk("ovr_consumed_queue", exp_q.size(), 0);

      // 6-cycle glitch: busy only for the half-bit start check, no frame
      busy_cnt[0] = 0;
      rx[0] = 1'b0;
      tick(6);
      rx[0] = 1'b1;
      tick(40);
      chk("glitch_busy_cycles", busy_cnt[0], CPB / 2);
      chk("glitch_no_valid", 32'(valid[0]), 0);
      chk("glitch_busy_end", 32'(busy[0]), 0);

      // randomized frames on every configuration
      for (int i = 0; i < NI; i++) begin
         for (int n = 0; n < 10; n++) begin
            d        = 9'($urandom) & mask_of(i);
            flip     = (pmode_of(i) != 0) && ($urandom_range(0, 3) == 0);
            stops[0] = ($urandom_range(0, 4) != 0);
            stops[1] = ($urandom_range(0, 4) != 0);
            rdy      = 1'($urandom_range(0, 1));
            ready[i] = rdy;
            expect_frame(i, d, flip, stops);
            send(i, d, flip, stops);
            if (!rdy) begin
               tick($urandom_range(0, 20));
               ready[i] = 1'b1;
            end
            wait_drain($sformatf("rand_drain_inst%0d_%0d", i, n));
            ready[i] = 1'b0;
         end
      end

      // 9-bit, two stop bits: full word, then second stop bit low
      ready[2] = 1'b1;
      expect_frame(2, 9'h1FF, 1'b0, 2'b11);
      send(2, 9'h1FF, 1'b0, 2'b11);
      expect_frame(2, 9'h1FF, 1'b0, 2'b01);
      send(2, 9'h1FF, 1'b0, 2'b01);
      wait_drain("c_drain");
      ready[2] = 1'b0;

      // reset mid-frame while a word is pending: everything returns to zero at once
      send(2, 9'h155, 1'b0, 2'b11);
      chk("c_pending_valid", 32'(valid[2]), 1);
      rx[2] = 1'b0;
      tick(4 * CPB);
      chk("c_midframe_busy", 32'(busy[2]), 1);
      rst = 1'b1;
      #1;
      chk("rst_mid_outputs", 32'({valid[2], busy[2], ovr[2], ferr[2], perr[2], dout[2]}), 0);
      rx[2] = 1'b1;
      tick(3);
      rst = 1'b0;
      tick(4);
      chk("rst_after_idle", 32'({valid[2], busy[2]}), 0);
      ready[2] = 1'b1;
      expect_frame(2, 9'h0A3, 1'b0, 2'b11);
      send(2, 9'h0A3, 1'b0, 2'b11);
      wait_drain("c_post_reset_drain");
      ready[2] = 1'b0;

      for (int i = 0; i < NI; i++) begin
         chk($sformatf("overrun_total_inst%0d", i), ovr_seen[i], exp_ovr[i]);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
